// File: rtl/patch_streamer_if.sv
// Beat-stream bundle between patch_streamer (master) and the patch-embedding
// projection (slave).
interface patch_streamer_if #(
  parameter int DATA_W = 96,
  parameter int PIDX_W = 4,
  parameter int BIDX_W = 6
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PIDX_W-1:0] out_patch_idx;
  logic [BIDX_W-1:0] out_beat_idx;
  logic              out_last_beat;
  logic              out_last_patch;

  modport master (
    output out_valid, out_data, out_patch_idx, out_beat_idx,
           out_last_beat, out_last_patch,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_patch_idx, out_beat_idx,
           out_last_beat, out_last_patch,
    output out_ready
  );
endinterface

// File: rtl/patch_streamer.sv
// Serialises a held, fully patchified frame into patch-major valid/ready beats.
// Optional CLS token (an all-zero leading patch) when PATCH_STREAMER_CLS_EN is defined.
module patch_streamer #(
  parameter int PIXEL_WIDTH       = 24,
  parameter int TOTAL_NUM_PATCHES = 16,
  parameter int PATCH_VECTOR_SIZE = 256,
  parameter int BEAT_PIXELS       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] all_patches [TOTAL_NUM_PATCHES-1:0][PATCH_VECTOR_SIZE-1:0],
  output logic                   output_taken,
  output logic                   busy,
  output logic [15:0]            frame_count,
  patch_streamer_if.master       out_if
);
  localparam int BEATS_PER_PATCH = PATCH_VECTOR_SIZE / BEAT_PIXELS;
`ifdef PATCH_STREAMER_CLS_EN
  localparam int NUM_OUT_PATCHES = TOTAL_NUM_PATCHES + 1;
`else
  localparam int NUM_OUT_PATCHES = TOTAL_NUM_PATCHES;
`endif
  localparam int PIDX_W = $clog2(NUM_OUT_PATCHES);
  localparam int BIDX_W = $clog2(BEATS_PER_PATCH);
  localparam int SRC_W  = $clog2(TOTAL_NUM_PATCHES);
  localparam int POS_W  = $clog2(PATCH_VECTOR_SIZE);
  localparam int DATA_W = BEAT_PIXELS * PIXEL_WIDTH;
  localparam logic [BIDX_W-1:0] LAST_BEAT  = BIDX_W'(BEATS_PER_PATCH - 1);
  localparam logic [PIDX_W-1:0] LAST_PATCH = PIDX_W'(NUM_OUT_PATCHES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BIDX_W-1:0]   beat_r;
  logic [PIDX_W-1:0]   patch_r;
  logic [15:0]         frame_count_r;
  logic                valid_s;
  logic                handshake_s;
  logic                last_beat_s;
  logic                last_patch_s;
  logic                zero_s;
  logic [SRC_W-1:0]    src_s;
  logic [DATA_W-1:0]   data_s;

  assign handshake_s  = valid_s && out_if.out_ready;
  assign last_beat_s  = (beat_r == LAST_BEAT);
  assign last_patch_s = (patch_r == LAST_PATCH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an upstream drop wins over a coincident final handshake
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = STREAM;
        else          state_s = IDLE;
      end
      STREAM: begin
        if (!in_valid)                                       state_s = IDLE;
        else if (handshake_s && last_beat_s && last_patch_s) state_s = RELEASE;
        else                                                 state_s = STREAM;
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode straight from the state register
  always_comb begin
    valid_s      = 1'b0;
    output_taken = 1'b0;
    busy         = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s      = 1'b0;
        output_taken = 1'b0;
        busy         = 1'b0;
      end
      STREAM: begin
        valid_s = 1'b1;
        busy    = 1'b1;
      end
      RELEASE: begin
        output_taken = 1'b1;
        busy         = 1'b1;
      end
      default: begin
        valid_s      = 1'b0;
        output_taken = 1'b0;
        busy         = 1'b0;
      end
    endcase
  end

  // Beat/patch counters; held at zero outside an active stream
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_r  <= {BIDX_W{1'b0}};
      patch_r <= {PIDX_W{1'b0}};
    end else if (state_r != STREAM || !in_valid) begin
      beat_r  <= {BIDX_W{1'b0}};
      patch_r <= {PIDX_W{1'b0}};
    end else if (handshake_s) begin
      if (last_beat_s) begin
        beat_r  <= {BIDX_W{1'b0}};
        patch_r <= last_patch_s ? {PIDX_W{1'b0}} : patch_r + PIDX_W'(1);
      end else begin
        beat_r  <= beat_r + BIDX_W'(1);
      end
    end else begin
      beat_r  <= beat_r;
      patch_r <= patch_r;
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_r <= 16'd0;
    end else if (state_r == RELEASE) begin
      frame_count_r <= frame_count_r + 16'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  // Map output patch index to a source patch (CLS occupies output slot 0)
  always_comb begin
`ifdef PATCH_STREAMER_CLS_EN
    zero_s = (patch_r == {PIDX_W{1'b0}});
    src_s  = SRC_W'(patch_r - PIDX_W'(1));
`else
    zero_s = 1'b0;
    src_s  = SRC_W'(patch_r);
`endif
  end

  // Beat data mux; forced to zero when no beat is offered
  always_comb begin
    data_s = {DATA_W{1'b0}};
    for (int k = 0; k < BEAT_PIXELS; k++) begin
      if (valid_s && !zero_s) begin
        data_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] =
          all_patches[src_s][POS_W'(beat_r) * POS_W'(BEAT_PIXELS) + POS_W'(k)];
      end else begin
        data_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = {PIXEL_WIDTH{1'b0}};
      end
    end
  end

  assign out_if.out_valid      = valid_s;
  assign out_if.out_data       = data_s;
  assign out_if.out_patch_idx  = patch_r;
  assign out_if.out_beat_idx   = beat_r;
  assign out_if.out_last_beat  = valid_s && last_beat_s;
  assign out_if.out_last_patch = valid_s && last_patch_s;
  assign frame_count           = frame_count_r;
endmodule

// File: tb/tb_patch_streamer.sv
// Randomised bench for patch_streamer: beats are compared against a frame-index
// reference model (beat n -> patch n/BPP, beat n%BPP).
module tb_patch_streamer;
  localparam int PW  = 24;
  localparam int NP  = 16;
  localparam int PVS = 256;
  localparam int BP  = 4;
  localparam int BPP = PVS / BP;
`ifdef PATCH_STREAMER_CLS_EN
  localparam int NOUT = NP + 1;
`else
  localparam int NOUT = NP;
`endif
  localparam int PIDX_W = $clog2(NOUT);
  localparam int BIDX_W = $clog2(BPP);
  localparam int DW     = BP * PW;
  localparam int TOTAL  = NOUT * BPP;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [PW-1:0] pix [NP-1:0][PVS-1:0];
  logic          output_taken;
  logic          busy;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int fc_exp   = 0;

  patch_streamer_if #(.DATA_W(DW), .PIDX_W(PIDX_W), .BIDX_W(BIDX_W)) sif ();

  patch_streamer #(
    .PIXEL_WIDTH(PW), .TOTAL_NUM_PATCHES(NP),
    .PATCH_VECTOR_SIZE(PVS), .BEAT_PIXELS(BP)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .all_patches(pix),
    .output_taken(output_taken), .busy(busy), .frame_count(frame_count),
    .out_if(sif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // pixel = {random byte, patch, position}
  task automatic fill_frame();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < PVS; i++)
        pix[p][i] = {8'($urandom), 8'(p), 8'(i)};
  endtask

  function automatic logic [DW-1:0] exp_beat(input int n);
    int p = n / BPP;
    int b = n % BPP;
    logic [DW-1:0] d = {DW{1'b0}};
    for (int k = 0; k < BP; k++) begin
`ifdef PATCH_STREAMER_CLS_EN
      if (p > 0) d[k*PW +: PW] = pix[p-1][b*BP + k];
`else
      d[k*PW +: PW] = pix[p][b*BP + k];
`endif
    end
    return d;
  endfunction

  // Stream one frame; optionally stop it after stop_at accepted beats by reset or abort.
  task automatic run_frame(input int ready_pct, input int stop_at, input bit by_reset, input bit keep_valid);
    int n = 0;
    int cyc = 0;
    int last_hs = -10;
    bit done = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    logic [DW-1:0] held = {DW{1'b0}};
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("first_beat_valid", sif.out_valid, 1'b1);
    while (!done && cyc < 20000) begin
      if (output_taken) begin
        check_eq("taken_beats", n, TOTAL);
        check_eq("taken_latency", cyc, last_hs + 1);
        check_eq("taken_no_valid", sif.out_valid, 1'b0);
        if (ready_pct == 100) check_eq("stream_cycles", cyc, TOTAL);
        in_valid = keep_valid;
        sif.out_ready = 1'b0;
        done = 1'b1;
      end else if (stop_at >= 0 && n == stop_at) begin
        sif.out_ready = 1'b0;
        in_valid = 1'b0;
        if (by_reset) begin
          reset = 1'b1;
          fc_exp = 0;
        end
        @(negedge clk);
        check_eq("stop_valid", sif.out_valid, 1'b0);
        check_eq("stop_busy", busy, 1'b0);
        check_eq("stop_taken", output_taken, 1'b0);
        check_eq("stop_frame_count", frame_count, fc_exp);
        check_eq("stop_data_zero", sif.out_data, {DW{1'b0}});
        reset = 1'b0;
        @(negedge clk);
        check_eq("stop_no_taken_later", output_taken, 1'b0);
        check_eq("stop_stays_idle", busy, 1'b0);
        return;
      end else begin
        check_eq("valid", sif.out_valid, 1'b1);
        if (!sif.out_valid) break;
        if (stalled) check_eq("stall_hold", sif.out_data, held);
        check_eq("data", sif.out_data, exp_beat(n));
        check_eq("patch_idx", sif.out_patch_idx, n / BPP);
        check_eq("beat_idx", sif.out_beat_idx, n % BPP);
        check_eq("last_beat", sif.out_last_beat, (n % BPP) == BPP - 1);
        check_eq("last_patch", sif.out_last_patch, (n / BPP) == NOUT - 1);
        rdy = ($urandom_range(0, 99) < ready_pct);
        sif.out_ready = rdy;
        stalled = !rdy;
        held = sif.out_data;
        if (rdy) begin
          n++;
          last_hs = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("frame_done", done, 1'b1);
    if (done) begin
      @(negedge clk);
      fc_exp++;
      check_eq("idle_gap_valid", sif.out_valid, 1'b0);
      check_eq("idle_gap_busy", busy, 1'b0);
      check_eq("idle_gap_taken", output_taken, 1'b0);
      check_eq("frame_count", frame_count, fc_exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    sif.out_ready = 1'b0;
    fill_frame();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", sif.out_valid, 1'b0);
    check_eq("rst_taken", output_taken, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_frame_count", frame_count, 16'd0);
    check_eq("rst_patch_idx", sif.out_patch_idx, 0);
    check_eq("rst_beat_idx", sif.out_beat_idx, 0);
    check_eq("rst_data", sif.out_data, {DW{1'b0}});
    reset = 1'b0;
    @(negedge clk);

    run_frame(100, -1, 1'b0, 1'b0);
    fill_frame();
    run_frame(30, -1, 1'b0, 1'b0);
    fill_frame();
    run_frame(100, 100, 1'b1, 1'b0);
    fill_frame();
    run_frame(70, 500, 1'b0, 1'b0);
    run_frame(100, -1, 1'b0, 1'b0);
    fill_frame();
    run_frame(100, -1, 1'b0, 1'b1);
    run_frame(50, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
